// File: rtl/alu_in.sv
// alu_in: single-cycle ALU with a registered result, carry/zero/neg/ovf
// flags and an internal running accumulator.
//
// Ports
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   a, b  : WIDTH-bit operands (shifts use only b[$clog2(WIDTH)-1:0])
//   op    : 3-bit operation select
//           000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//           101 SLL, 110 SRL, 111 ACC (acc <= acc + a)
//   sum   : registered result
//   carry : registered carry / borrow / last shifted-out bit
//   zero  : registered, 1 when sum is all zeros
//   neg   : registered copy of sum[WIDTH-1]
//   ovf   : registered signed-overflow flag (ADD, SUB, ACC only)
module alu_in #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int SW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int MSB = WIDTH - 1;

  logic [SW-1:0]    shamt_s;
  logic [WIDTH:0]   wide_s;    // {carry-out, result} for arithmetic and SLL
  logic [WIDTH:0]   srl_s;     // {result, last bit shifted out} for SRL
  logic [WIDTH-1:0] res_s;
  logic             carry_s;
  logic             ovf_s;
  logic [WIDTH-1:0] acc_r;

  assign shamt_s = b[SW-1:0];

  // Combinational result and flag generation for the selected operation.
  always_comb begin
    wide_s  = {(WIDTH+1){1'b0}};
    srl_s   = {(WIDTH+1){1'b0}};
    res_s   = {WIDTH{1'b0}};
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    case (op)
      3'b000: begin
        wide_s  = {1'b0, a} + {1'b0, b};
        res_s   = wide_s[WIDTH-1:0];
        carry_s = wide_s[WIDTH];
        ovf_s   = (a[MSB] == b[MSB]) && (res_s[MSB] != a[MSB]);
      end
      3'b001: begin
        // The extra top bit of a zero-extended subtraction is the borrow.
        wide_s  = {1'b0, a} - {1'b0, b};
        res_s   = wide_s[WIDTH-1:0];
        carry_s = wide_s[WIDTH];
        ovf_s   = (a[MSB] != b[MSB]) && (res_s[MSB] != a[MSB]);
      end
      3'b010: res_s = a & b;
      3'b011: res_s = a | b;
      3'b100: res_s = a ^ b;
      3'b101: begin
        // Bit WIDTH captures the last bit pushed out of the MSB; zero
        // when shamt is zero because the guard bit starts clear.
        wide_s  = {1'b0, a} << shamt_s;
        res_s   = wide_s[WIDTH-1:0];
        carry_s = wide_s[WIDTH];
      end
      3'b110: begin
        // Guard bit below the LSB catches the last bit shifted out.
        srl_s   = {a, 1'b0} >> shamt_s;
        res_s   = srl_s[WIDTH:1];
        carry_s = srl_s[0];
      end
      3'b111: begin
        wide_s  = {1'b0, acc_r} + {1'b0, a};
        res_s   = wide_s[WIDTH-1:0];
        carry_s = wide_s[WIDTH];
        ovf_s   = (acc_r[MSB] == a[MSB]) && (res_s[MSB] != acc_r[MSB]);
      end
      default: begin
        res_s   = {WIDTH{1'b0}};
        carry_s = 1'b0;
        ovf_s   = 1'b0;
      end
    endcase
  end

  // Output and accumulator registers; acc only advances on ACC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= {WIDTH{1'b0}};
      carry <= 1'b0;
      zero  <= 1'b1;
      neg   <= 1'b0;
      ovf   <= 1'b0;
      acc_r <= {WIDTH{1'b0}};
    end else begin
      sum   <= res_s;
      carry <= carry_s;
      zero  <= (res_s == {WIDTH{1'b0}});
      neg   <= res_s[MSB];
      ovf   <= ovf_s;
      if (op == 3'b111) begin
        acc_r <= res_s;
      end else begin
        acc_r <= acc_r;
      end
    end
  end

endmodule

// File: tb/tb_alu_in.sv
// Directed self-checking bench for alu_in (WIDTH = 16).
module tb_alu_in;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  op;
  logic [15:0] sum;
  logic        carry;
  logic        zero;
  logic        neg;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  alu_in #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .op    (op),
    .sum   (sum),
    .carry (carry),
    .zero  (zero),
    .neg   (neg),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the full output set against expected sum/carry/ovf; zero and neg
  // are derived from the expected sum.
  task automatic chk_all(input string tag, input logic [15:0] es,
                         input logic ec, input logic eo);
    chk({tag, ".sum"},   sum,          es);
    chk({tag, ".carry"}, {15'd0, carry}, {15'd0, ec});
    chk({tag, ".ovf"},   {15'd0, ovf},   {15'd0, eo});
    chk({tag, ".zero"},  {15'd0, zero},  {15'd0, (es == 16'd0)});
    chk({tag, ".neg"},   {15'd0, neg},   {15'd0, es[15]});
  endtask

  // Apply one vector, wait one rising edge, settle 1 time unit.
  task automatic step(input logic [15:0] va, input logic [15:0] vb, input logic [2:0] vop);
    a  = va;
    b  = vb;
    op = vop;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a     = 16'd0;
    b     = 16'd0;
    op    = 3'b000;
    #12;
    chk_all("reset", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // SRL sweep, b=1.
    for (int i = 0; i < 10; i++) begin
      step(i[15:0], 16'd1, 3'b110);
      chk($sformatf("srl_sweep%0d.sum", i), sum, 16'(i / 2));
      chk($sformatf("srl_sweep%0d.carry", i), {15'd0, carry}, {15'd0, i[0]});
    end

    step(16'hFFFF, 16'h0001, 3'b000);
    chk_all("add_wrap", 16'h0000, 1'b1, 1'b0);
    step(16'h7FFF, 16'h0001, 3'b000);
    chk_all("add_ovf", 16'h8000, 1'b0, 1'b1);
    step(16'h0000, 16'h0001, 3'b001);
    chk_all("sub_borrow", 16'hFFFF, 1'b1, 1'b0);
    step(16'h8000, 16'h0001, 3'b001);
    chk_all("sub_ovf", 16'h7FFF, 1'b0, 1'b1);
    step(16'h0009, 16'h0004, 3'b001);
    chk_all("sub_plain", 16'h0005, 1'b0, 1'b0);

    step(16'hF0F0, 16'h0FF0, 3'b010);
    chk_all("and", 16'h00F0, 1'b0, 1'b0);
    step(16'hF0F0, 16'h0FF0, 3'b011);
    chk_all("or", 16'hFFF0, 1'b0, 1'b0);
    step(16'hF0F0, 16'h0FF0, 3'b100);
    chk_all("xor", 16'hFF00, 1'b0, 1'b0);

    step(16'h8001, 16'h0004, 3'b101);
    chk_all("sll4", 16'h0010, 1'b0, 1'b0);
    step(16'h1801, 16'h0004, 3'b101);
    chk_all("sll4_carry", 16'h8010, 1'b1, 1'b0);
    step(16'h1234, 16'h0000, 3'b101);
    chk_all("sll0", 16'h1234, 1'b0, 1'b0);
    step(16'h8003, 16'h0010, 3'b110);
    chk_all("srl_shamt0", 16'h8003, 1'b0, 1'b0);
    step(16'h0003, 16'h0011, 3'b110);
    chk_all("srl_hibits_ignored", 16'h0001, 1'b1, 1'b0);
    step(16'h8000, 16'h000F, 3'b110);
    chk_all("srl15", 16'h0001, 1'b0, 1'b0);

    // Accumulator chain from a fresh reset.
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    step(16'h0005, 16'h0000, 3'b111);
    chk_all("acc1", 16'h0005, 1'b0, 1'b0);
    step(16'h0007, 16'h0000, 3'b111);
    chk_all("acc2", 16'h000C, 1'b0, 1'b0);
    step(16'hFFFF, 16'h0000, 3'b111);
    chk_all("acc3", 16'h000B, 1'b1, 1'b0);
    step(16'h4444, 16'h1111, 3'b000);
    chk_all("add_between", 16'h5555, 1'b0, 1'b0);
    step(16'h0001, 16'h0000, 3'b111);
    chk_all("acc_held", 16'h000C, 1'b0, 1'b0);
    step(16'h7FF4, 16'h0000, 3'b111);
    chk_all("acc_ovf", 16'h8000, 1'b0, 1'b1);

    // Mid-stream async reset, asserted between edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    chk_all("rst_held", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(16'h0003, 16'h0000, 3'b111);
    chk_all("acc_after_rst", 16'h0003, 1'b0, 1'b0);
    step(16'h0004, 16'h0000, 3'b111);
    chk_all("acc_after_rst2", 16'h0007, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
